multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control-unit FSM for the team's multicycle 32-bit MIPS-subset datapath. It drives the ALU's 3-bit alu_ctrl and the datapath mux/enable signals, and consumes the ALU zero flag for branch resolution.
- Sits between the instruction register (op/funct fields) and the shared datapath: register file, ALU, PC, and unified memory.

Parameters:
- none. The instruction subset is fixed; encodings live in the shared package.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  IR[31:26], stable from the cycle after FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid combinationally in BRANCH state
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  IR load enable
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A: 0 = PC, 1 = regA
- alu_src_b  out  2  ALU B: 00 = regB, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_ctrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load enable
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported op or R-type funct

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
- R-type funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- State register uses 4-bit encoding and resets asynchronously to FETCH.
- While reset is high, ir_write, pc_en, reg_write, mem_write and illegal_op are all forced 0. Every other output takes its FETCH value.
- Outputs are Moore-decoded from state. The only exception is pc_en in BRANCH, which depends on zero.
- Any output not listed for a state is 0.
- FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00, pc_en=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (precomputes the branch target). Next state by op:
  - lw/sw -> MEMADR
  - R -> EXECUTE
  - beq/bne -> BRANCH
  - addi -> ADDIEX
  - j -> JUMP
  - illegal -> FETCH with illegal_op=1
  - R-type with an unknown funct also counts as illegal.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next state is MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next state is FETCH.
- MEMWR: iord=1, mem_write=1. Next state is FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl decoded from funct. Next state is ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=SUB, pc_src=01. Next state is FETCH.
  - beq: pc_en = zero
  - bne: pc_en = ~zero
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD. Next state is ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next state is FETCH.
- JUMP: pc_src=10, pc_en=1. Next state is FETCH.
- Cycle counts, including FETCH:
  - lw 5
  - sw 4
  - R 4
  - addi 4
  - beq/bne 3
  - j 3
  - illegal 2
- Reset asserted mid-instruction: state goes to FETCH immediately. No partial write is issued afterwards.
- First FETCH after reset release occurs on the first rising edge with reset low.
- Undefined state encodings return to FETCH with all enables 0.

Decomposition:
- Shared package `mips_pkg` holds:
  - opcode and funct localparams
  - ALU_AND/OR/ADD/SUB/SLT 3-bit codes
  - state encodings
  - alu_src_b and pc_src codes
- Sub-module `alu_decoder` is combinational: (alu_op[1:0], funct) -> alu_ctrl plus funct_valid. alu_op 00 = ADD, 01 = SUB, 10 = use funct.
- FSM top: multicycle_controller.

Test Plan:
- Reset high with random op -> all enables 0. Release, then first edge: FETCH outputs with ir_write=1, pc_en=1, alu_ctrl=010.
- lw (op=100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMWB shows mem_to_reg=1, reg_write=1. Back in FETCH on cycle 6.
- R-type slt (funct=101010) -> EXECUTE alu_ctrl=111. ALUWB reg_dst=1, reg_write=1. Repeat for and/or/add/sub expecting 000/001/010/110.
- beq with zero=1 -> BRANCH pc_en=1, pc_src=01. beq with zero=0 -> pc_en=0. bne with zero=0 -> pc_en=1.
- op=111111, and R-type funct=000000 -> illegal_op pulses one cycle in DECODE. No reg_write or mem_write. FETCH follows.
- Assert reset during MEMWR (sw) -> mem_write drops asynchronously. After release, the FSM restarts in FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-subset datapath: opcodes, functs,
// ALU controls, mux selects and controller states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode. funct_valid reflects the funct field
// independently of alu_op so DECODE can flag unknown R-type functs.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_valid
);

  logic [2:0] fn_ctrl;

  always_comb begin
    fn_ctrl     = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  fn_ctrl = ALU_ADD;
      FN_SUB:  fn_ctrl = ALU_SUB;
      FN_AND:  fn_ctrl = ALU_AND;
      FN_OR:   fn_ctrl = ALU_OR;
      FN_SLT:  fn_ctrl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:   alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: alu_ctrl = fn_ctrl;
      default:     alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: Moore outputs per state, except pc_en
// in BRANCH which follows the zero flag (beq) or its inverse (bne).
//   state   | meaning
//   FETCH   | IR <= mem[PC], PC <= PC+4
//   DECODE  | read regs, ALUOut <= branch target; dispatch on op
//   MEMADR  | ALUOut <= regA + imm
//   MEMRD   | MDR <= mem[ALUOut]
//   MEMWB   | rt <= MDR
//   MEMWR   | mem[ALUOut] <= regB
//   EXECUTE | ALUOut <= regA op regB
//   ALUWB   | rd <= ALUOut
//   BRANCH  | compare; PC <= ALUOut if taken
//   ADDIEX  | ALUOut <= regA + imm
//   ADDIWB  | rt <= ALUOut
//   JUMP    | PC <= jump target
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       funct_valid;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_ctrl    (alu_ctrl),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    pc_en      = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_en     = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_valid) state_d = S_EXECUTE;
            else             illegal_op = 1'b1;
          end
          default:        illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        // op[0] separates bne (000101) from beq (000100)
        pc_en     = op[0] ? ~zero : zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_en  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // State is already FETCH asynchronously; mask its side-effecting enables.
    if (reset) begin
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-cycle output vectors of whole instructions
// compared against a step-indexed instruction model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [15:0] got;

  int tests = 0;
  int fails = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  assign got = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, illegal_op};

  // ---------------- reference model ----------------
  function automatic logic [15:0] mk(input logic io, mw, irw, rd, m2r, rw, asa,
                                     input logic [1:0] asb, input logic [2:0] ac,
                                     input logic [1:0] ps, input logic pce, ill);
    return {io, mw, irw, rd, m2r, rw, asa, asb, ac, ps, pce, ill};
  endfunction

  function automatic bit funct_ok(input logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
           f == 6'b100101 || f == 6'b101010;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  function automatic int inst_len(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000000: return funct_ok(f) ? 4 : 2;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000100, 6'b000101: return 3;
      6'b001000: return 4;
      6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  // Expected outputs on cycle k (0 = fetch) of executing instruction (o,f).
  function automatic logic [15:0] exp_out(input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input int k);
    if (k == 0) return mk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0);
    if (k == 1) return mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0, inst_len(o, f) == 2);
    case (o)
      6'b100011, 6'b101011: begin
        if (k == 2) return mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
        if (o == 6'b101011) return mk(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
        if (k == 3) return mk(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
        return mk(0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0,0);
      end
      6'b000000: begin
        if (k == 2) return mk(0,0,0,0,0,0,1,2'b00,funct_alu(f),2'b00,0,0);
        return mk(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0);
      end
      6'b000100: return mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,z,0);
      6'b000101: return mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,~z,0);
      6'b001000: begin
        if (k == 2) return mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
        return mk(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0,0);
      end
      default: return mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0);
    endcase
  endfunction

  localparam logic [15:0] RESET_VEC = 16'b0000000_01_010_00_0_0;

  // Entered at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input string name);
    int n;
    logic [15:0] exp;
    op = o; funct = f; zero = z;
    n = inst_len(o, f);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      exp = exp_out(o, f, z, k);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, k, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; op = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
    @(negedge clk);
    tests++;
    if (got !== RESET_VEC) begin
      fails++; $display("FAIL reset_hold: got %b expected %b", got, RESET_VEC);
    end
    @(posedge clk); #1;
    op = 6'($urandom);
    tests++;
    if (got !== RESET_VEC) begin
      fails++; $display("FAIL reset_after_edge: got %b expected %b", got, RESET_VEC);
    end
    reset = 1'b0;
    run_instr(6'b100011, 6'($urandom), 1'b0, "lw_after_reset");
  endtask

  task automatic test_rtype();
    logic [5:0] fns [5] = '{6'b101010, 6'b100100, 6'b100101, 6'b100000, 6'b100010};
    foreach (fns[i]) run_instr(6'b000000, fns[i], 1'($urandom), "rtype");
  endtask

  task automatic test_branch();
    run_instr(6'b000100, 6'($urandom), 1'b1, "beq_taken");
    run_instr(6'b000100, 6'($urandom), 1'b0, "beq_not_taken");
    run_instr(6'b000101, 6'($urandom), 1'b0, "bne_taken");
    run_instr(6'b000101, 6'($urandom), 1'b1, "bne_not_taken");
    run_instr(6'b000010, 6'($urandom), 1'b0, "jump");
    run_instr(6'b001000, 6'($urandom), 1'b0, "addi");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 6'($urandom), 1'b0, "illegal_op");
    run_instr(6'b000000, 6'b000000, 1'b0, "illegal_funct");
    run_instr(6'b101011, 6'($urandom), 1'b0, "sw_after_illegal");
  endtask

  task automatic test_reset_mid_sw();
    op = 6'b101011; funct = 6'($urandom); zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if (mem_write !== 1'b1) begin
      fails++; $display("FAIL memwr_before_reset: got %b expected 1", mem_write);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (got !== RESET_VEC) begin
      fails++; $display("FAIL reset_async_memwr: got %b expected %b", got, RESET_VEC);
    end
    @(posedge clk); #1;
    tests++;
    if (got !== RESET_VEC) begin
      fails++; $display("FAIL reset_mid_hold: got %b expected %b", got, RESET_VEC);
    end
    reset = 1'b0;
    run_instr(6'b100011, 6'($urandom), 1'b0, "lw_after_mid_reset");
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                            6'b000101, 6'b001000, 6'b000010};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] o, f;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) o = 6'($urandom);
      else o = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else f = fns[$urandom_range(0, 4)];
      run_instr(o, f, 1'($urandom), "random");
    end
  endtask

  initial begin
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
    test_reset();
    run_instr(6'b100011, 6'($urandom), 1'b0, "lw");
    test_rtype();
    test_branch();
    test_illegal();
    test_reset_mid_sw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
